// File: rtl/mem_stage_pkg.sv
// Shared bus widths and field layouts for the EXE->MEM->WB boundary of the pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Widths match the values exe_stage and wb_stage are built with; keep them in step.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int STALL_BUS_WD    = 6;
  localparam int FORWARD_BUS_WD  = 33;

  // Instruction as handed over by EXE.
  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  // Instruction as handed on to WB.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // Register-write hazard info for ID's interlock.
  typedef struct packed {
    logic       vld;
    logic [4:0] dest;
  } stall_t;

  // Bypass value for ID's operand forwarding.
  typedef struct packed {
    logic        vld;
    logic [31:0] dat;
  } forward_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: picks ALU result or SRAM load data and hands it to WB.
// Latency: 1 cycle from EXE transfer to ms_to_ws_valid; loads take no extra cycle.
// Backpressure: holds one instruction while ws_allowin=0 (ms_allowin drops); load data is buffered so it survives the stall.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   ws_allowin / ms_allowin        WB can accept / MEM can accept this cycle
//   es_to_ms_valid, es_to_ms_bus   instruction from EXE {res_from_mem, gr_we, dest, alu_result, pc}
//   ms_to_ws_valid, ms_to_ws_bus   instruction to WB {gr_we, dest, final_result, pc}
//   stall_ms_bus                   {ms_valid && gr_we, dest} to ID
//   forward_ms_bus                 {ms_valid && gr_we, final_result} to ID
//   data_sram_rdata                SRAM read data for the address EXE drove last cycle
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
  input  logic [31:0]                data_sram_rdata
);

  logic        ms_valid;
  logic        ms_ready_go;
  logic        ms_first;
  logic        es_fire;
  es_to_ms_t   ms_inst;
  logic [31:0] rdata_buf;
  logic [31:0] mem_rdata;
  logic [31:0] final_result;
  logic        wr_vld;
  ms_to_ws_t   ws_dat;
  stall_t      stall_dat;
  forward_t    fwd_dat;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign es_fire        = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_inst <= '0;
    end else if (es_fire) begin
      ms_inst <= es_to_ms_bus;
    end
  end

  // ms_first marks the one cycle in which the SRAM output belongs to the
  // instruction just received; the read was launched as it left EXE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_first <= 1'b0;
    end else begin
      ms_first <= es_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data hold
  // ---------------------------------------------------------------------------
  // The SRAM output moves on once EXE issues its next access, so the data is
  // captured on the first cycle and served from the buffer for the rest of
  // any WB stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf <= '0;
    end else if (ms_first) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign mem_rdata    = ms_first ? data_sram_rdata : rdata_buf;
  assign final_result = ms_inst.res_from_mem ? mem_rdata : ms_inst.alu_result;

  // ---------------------------------------------------------------------------
  // Output buses
  // ---------------------------------------------------------------------------
  assign wr_vld = ms_valid && ms_inst.gr_we;

  always_comb begin
    ws_dat              = '0;
    ws_dat.gr_we        = ms_inst.gr_we;
    ws_dat.dest         = ms_inst.dest;
    ws_dat.final_result = final_result;
    ws_dat.pc           = ms_inst.pc;
  end

  always_comb begin
    stall_dat      = '0;
    stall_dat.vld  = wr_vld;
    stall_dat.dest = ms_inst.dest;
  end

  always_comb begin
    fwd_dat     = '0;
    fwd_dat.vld = wr_vld;
    fwd_dat.dat = final_result;
  end

  assign ms_to_ws_bus   = ws_dat;
  assign stall_ms_bus   = stall_dat;
  assign forward_ms_bus = fwd_dat;

endmodule
